// File: rtl/rr_burst_arbiter_pkg.sv
// rr_burst_arbiter_pkg: shared FSM state type and width helpers for the burst arbiter
package rr_burst_arbiter_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// rr_burst_arbiter_if: FIFO-bank status in, pop request/select out
interface rr_burst_arbiter_if
    import rr_burst_arbiter_pkg::*;
#(
    parameter int NUM_FIFOS = 4,
    parameter int MAX_BURST = 2
);
    localparam int TAGWIDTH = tag_w(NUM_FIFOS);
    localparam int CNTW     = cnt_w(MAX_BURST);

    logic [NUM_FIFOS-1:0] empty;
    logic                 ds_ready;
    logic                 req;
    logic [TAGWIDTH-1:0]  gnt_sel;
    logic [NUM_FIFOS-1:0] gnt;
    logic [CNTW-1:0]      burst_cnt;

    modport master (input empty, ds_ready, output req, gnt_sel, gnt, burst_cnt);
    modport slave  (output empty, ds_ready, input req, gnt_sel, gnt, burst_cnt);

endinterface

// File: rtl/rr_burst_arbiter_pick.sv
// rr_priority_pick: first set bit of i_vec at or after i_start, wrapping around
module rr_priority_pick
    import rr_burst_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int TW = tag_w(N)
) (
    input  logic [N-1:0]  i_vec,
    input  logic [TW-1:0] i_start,
    output logic [TW-1:0] o_idx,
    output logic          o_found
);
    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_vec[TW'((int'(i_start) + k) % N)]) begin
                o_idx   = TW'((int'(i_start) + k) % N);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin pop arbiter letting an owner hold the grant for up to MAX_BURST pops
module rr_burst_arbiter
    import rr_burst_arbiter_pkg::*;
#(
    parameter int NUM_FIFOS = 4,
    parameter int MAX_BURST = 2
) (
    input logic                clk,
    input logic                rst,
    rr_burst_arbiter_if.master bus
);
    localparam int TAGWIDTH = tag_w(NUM_FIFOS);
    localparam int CNTW     = cnt_w(MAX_BURST);

    state_t               r_state, w_state_nx;
    logic [TAGWIDTH-1:0]  r_last, w_last_nx, w_start, w_cand, w_sel;
    logic [CNTW-1:0]      r_cnt, w_cnt_nx;
    logic [NUM_FIFOS-1:0] w_avail;
    logic                 w_any, w_hold, w_req;

    assign w_avail = ~bus.empty;
    assign w_start = (r_last == TAGWIDTH'(NUM_FIFOS - 1)) ? '0 : r_last + 1'b1;

    rr_priority_pick #(.N(NUM_FIFOS), .TW(TAGWIDTH)) u_pick (
        .i_vec   (w_avail),
        .i_start (w_start),
        .o_idx   (w_cand),
        .o_found (w_any)
    );

    assign w_hold = (r_state == BURST) && w_avail[r_last] && (r_cnt < CNTW'(MAX_BURST));
    assign w_sel  = w_hold ? r_last : w_cand;
    assign w_req  = bus.ds_ready & w_any & ~rst;

    assign bus.req       = w_req;
    assign bus.gnt_sel   = w_sel;
    assign bus.gnt       = w_req ? (NUM_FIFOS'(1) << w_sel) : '0;
    assign bus.burst_cnt = r_cnt;

    // Without a pop (ds_ready low) everything holds; an all-empty bank drops any burst.
    always_comb begin
        w_state_nx = r_state;
        w_last_nx  = r_last;
        w_cnt_nx   = r_cnt;
        if (!w_any) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
        end else if (w_req && w_hold) begin
            w_cnt_nx   = r_cnt + 1'b1;
            w_state_nx = (r_cnt == CNTW'(MAX_BURST - 1)) ? IDLE : BURST;
        end else if (w_req) begin
            w_last_nx  = w_sel;
            w_cnt_nx   = CNTW'(1);
            w_state_nx = (MAX_BURST > 1) ? BURST : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= TAGWIDTH'(NUM_FIFOS - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_last  <= w_last_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    a_nonempty: assert property (@(posedge clk) disable iff (rst) bus.req |-> !bus.empty[bus.gnt_sel]);
    a_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));

    // Per-FIFO count of pops given to others while this FIFO waits non-empty.
    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_fair
        logic [15:0] r_wait;
        always_ff @(posedge clk) begin
            r_wait <= (rst || !w_avail[g] || bus.gnt[g]) ? '0 : r_wait + 16'(w_req);
        end
        a_fair: assert property (@(posedge clk) disable iff (rst)
            r_wait <= 16'((NUM_FIFOS - 1) * MAX_BURST));
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb_rr_burst_arbiter: scoreboard bench comparing the arbiter against a round-robin burst model
module tb_rr_burst_arbiter;
    localparam int N  = 4;
    localparam int MB = 2;

    typedef struct {
        logic       chk_sel;
        logic       req;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic [1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_last = N - 1;
    int   m_cnt  = 0;

    rr_burst_arbiter_if #(.NUM_FIFOS(N), .MAX_BURST(MB)) bus ();

    rr_burst_arbiter #(.NUM_FIFOS(N), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst is live while the owner has taken between 1 and MB-1 pops and still has data;
    // otherwise the nearest non-empty FIFO after the last owner is chosen.
    task automatic step(input logic [3:0] emp, input logic rdy, input logic r);
        exp_t       e;
        logic [3:0] av;
        int         cand;
        bit         hold;
        av = ~emp;
        bus.empty    = emp;
        bus.ds_ready = rdy;
        rst          = r;
        hold = (m_cnt > 0) && (m_cnt < MB) && av[2'(m_last)];
        cand = m_last;
        for (int off = N; off >= 1; off--) begin
            if (av[2'((m_last + off) % N)]) cand = (m_last + off) % N;
        end
        e.sel     = 2'(hold ? m_last : cand);
        e.req     = rdy && (av != 4'b0) && !r;
        e.chk_sel = !r && (av != 4'b0);
        e.gnt     = e.req ? 4'(1 << e.sel) : 4'b0;
        e.cnt     = 2'(m_cnt);
        q.push_back(e);
        if (r) begin
            m_last = N - 1;
            m_cnt  = 0;
        end else if (av == 4'b0) begin
            m_cnt = 0;
        end else if (e.req) begin
            if (hold) m_cnt++;
            else begin
                m_last = int'(e.sel);
                m_cnt  = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("req", 32'(bus.req), 32'(e.req));
                check("gnt", 32'(bus.gnt), 32'(e.gnt));
                check("burst_cnt", 32'(bus.burst_cnt), 32'(e.cnt));
                if (e.chk_sel) check("gnt_sel", 32'(bus.gnt_sel), 32'(e.sel));
            end
        end
    end

    initial begin
        bus.empty    = 4'b1111;
        bus.ds_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        repeat (4) step(4'b1111, 1'b1, 1'b0);
        repeat (10) step(4'b0000, 1'b1, 1'b0);
        repeat (4) step(4'b1011, 1'b1, 1'b0);
        step(4'b1101, 1'b1, 1'b0);
        repeat (2) step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b1);
        repeat (7) step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b1);
        repeat (3) step(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
